// File: rtl/midi_msg_parser_if.sv
// Parsed-message stream between midi_msg_parser (master) and the voice logic (slave).
// valid/ready handshake; payload fields are meaningful only while msg_valid is high.
interface midi_msg_parser_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [2:0] msg_type;
  logic [3:0] msg_ch;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       note_on;
  logic       note_off;

  modport master (
    output msg_valid, msg_type, msg_ch, msg_d1, msg_d2, note_on, note_off,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_type, msg_ch, msg_d1, msg_d2, note_on, note_off,
    output msg_ready
  );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI channel-message parser with channel filter, output FIFO and drop counter.
// Define MIDI_RUNNING_STATUS_EN to keep the status byte live after each emitted message.
module midi_msg_parser #(
  parameter logic [15:0] CH_MASK    = 16'hFFFF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         din,
  input  logic               din_rdy,
  midi_msg_parser_if.master  msg,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2} state_e;

  typedef struct packed {
    logic [2:0] typ;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } msg_t;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam state_e StAfterEmit = StWaitD1;
`else
  localparam state_e StAfterEmit = StIdle;
`endif

  state_e     state_q, state_d;
  logic [2:0] typ_q;
  logic [3:0] ch_q;
  logic [6:0] d1_q;
  logic       pending_q;  // status seen, message not yet completed
  logic       sys_q;      // inside SysEx/system common: stray data is not counted

  logic is_data, is_chan, is_sys, one_byte;
  logic emit, abandon, idle_drop;
  msg_t emit_msg;

  assign is_data  = din_rdy & ~din[7];
  assign is_chan  = din_rdy & din[7] & (din[6:4] != 3'b111);
  assign is_sys   = din_rdy & (din[7:3] == 5'b11110);
  assign one_byte = (typ_q == 3'd4) || (typ_q == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_chan) begin
      state_d = StWaitD1;
    end else if (is_sys) begin
      state_d = StIdle;
    end else if (is_data) begin
      case (state_q)
        StWaitD1: state_d = one_byte ? StAfterEmit : StWaitD2;
        StWaitD2: state_d = StAfterEmit;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    abandon   = 1'b0;
    idle_drop = 1'b0;
    emit_msg  = '0;
    if (is_chan || is_sys) begin
      abandon = (state_q == StWaitD2) || ((state_q == StWaitD1) && pending_q);
    end else if (is_data) begin
      emit_msg.typ = typ_q;
      emit_msg.ch  = ch_q;
      case (state_q)
        StWaitD1: begin
          emit        = one_byte;
          emit_msg.d1 = din[6:0];
        end
        StWaitD2: begin
          emit        = 1'b1;
          emit_msg.d1 = d1_q;
          emit_msg.d2 = din[6:0];
        end
        default: idle_drop = ~sys_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typ_q     <= '0;
      ch_q      <= '0;
      d1_q      <= '0;
      pending_q <= 1'b0;
      sys_q     <= 1'b0;
    end else if (is_chan) begin
      typ_q     <= din[6:4];
      ch_q      <= din[3:0];
      d1_q      <= '0;
      pending_q <= 1'b1;
      sys_q     <= 1'b0;
    end else if (is_sys) begin
      pending_q <= 1'b0;
      sys_q     <= 1'b1;
    end else if (is_data) begin
      if (state_q == StWaitD1) d1_q <= din[6:0];
      if (emit) pending_q <= 1'b0;
    end
  end

  // Output FIFO: pointers carry one extra wrap bit to tell full from empty.
  msg_t          mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, pop, push_req, push, overflow;
  msg_t          head;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = ~empty & msg.msg_ready;
  assign push_req = emit & CH_MASK[emit_msg.ch];
  assign push     = push_req & (~full | pop);
  assign overflow = push_req & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= emit_msg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if ((abandon || idle_drop || overflow) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign msg.msg_valid = ~empty;
  assign msg.msg_type  = empty ? 3'd0 : head.typ;
  assign msg.msg_ch    = empty ? 4'd0 : head.ch;
  assign msg.msg_d1    = empty ? 7'd0 : head.d1;
  assign msg.msg_d2    = empty ? 7'd0 : head.d2;
  assign msg.note_on   = ~empty && (head.typ == 3'd1) && (head.d2 != 7'd0);
  assign msg.note_off  = ~empty && ((head.typ == 3'd0) || ((head.typ == 3'd1) && (head.d2 == 7'd0)));

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Parametrised MIDI channel-message parser sitting between the UART byte receiver and the synth voice logic. Accepts one byte per `din_rdy` strobe and tracks status and data bytes with a state machine, including running status. Filters channels and emits complete messages through a small output FIFO with a valid/ready handshake. Also flags note-on/note-off (velocity-0 note-on counts as note-off) and counts discarded messages.

## Interface
Parameters:
- `CH_MASK`, 16'hFFFF, bit n = 1 accepts MIDI channel n; messages on masked channels are parsed but not emitted
- `FIFO_DEPTH`, 4, output message queue depth; power of two, ≥ 2
- `CNT_W`, 8, width of the drop counter

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `din`  in  8  received MIDI byte
- `din_rdy`  in  1  one-cycle strobe; `din` is valid this cycle
- `msg_valid`  out  1  FIFO head holds a message
- `msg_ready`  in  1  consumer accepts head this cycle
- `msg_type`  out  3  status[6:4] (0 = note off, 1 = note on, … 6 = pitch bend)
- `msg_ch`  out  4  status[3:0]
- `msg_d1`  out  7  first data byte
- `msg_d2`  out  7  second data byte; 0 for 1-data-byte messages
- `note_on`  out  1  head is type 1 with `msg_d2` ≠ 0
- `note_off`  out  1  head is type 0, or type 1 with `msg_d2` == 0
- `drop_cnt`  out  CNT_W  saturating count of discarded messages

## Operation
- Byte classes:
  - 0x80–0xEF: channel status
  - 0xF0–0xF7: system common / SysEx
  - 0xF8–0xFF: realtime
  - 0x00–0x7F: data
- Message length: types 0–3 and 6 take 2 data bytes; types 4–5 take 1.
- FSM states: IDLE (no valid status), WAIT_D1, WAIT_D2. A byte is processed only when `din_rdy` = 1.
- Channel status byte in any state:
  - Latch type and channel, clear d1/d2, go to WAIT_D1.
  - If the state was WAIT_D2, or WAIT_D1 with no data byte yet since the status byte, the partial message is abandoned and `drop_cnt` increments.
- Data byte in WAIT_D1:
  - Latch d1.
  - For a 1-byte type, emit the message and stay in WAIT_D1 (running status).
  - Otherwise go to WAIT_D2.
- Data byte in WAIT_D2: latch d2, emit the message, go to WAIT_D1.
- Data byte in IDLE: discard it and increment `drop_cnt`.
- 0xF0–0xF7 in any state: abandon any partial message (counted as above), clear running status, go to IDLE. SysEx payload bytes that follow are data-in-IDLE bytes and are discarded without counting.
- 0xF8–0xFF: ignored entirely; state, latches and counter are unchanged. They may interleave anywhere.
- Emit behaviour:
  - If `CH_MASK[ch]` = 0, the message is silently discarded (no count).
  - Otherwise it is pushed into the FIFO.
  - If the FIFO is full and not popped that cycle, the message is lost and `drop_cnt` increments.
- Pop: the FIFO pops when `msg_valid && msg_ready`. A push and pop in the same cycle while full are both performed.
- `drop_cnt` saturates at all-ones. Two drop causes in one cycle cannot occur; at most one increment per cycle.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, running status cleared. Reset mid-message discards the partial message and all queued messages.

## Timing
- The completing data byte with `din_rdy` high at edge N is pushed at edge N; `msg_valid` and head fields are valid from the cycle after edge N (one-cycle latency).
- `msg_*`, `note_on` and `note_off` are driven combinationally from the FIFO head and are stable while `msg_valid && !msg_ready`.
- Back-to-back `din_rdy` on every cycle is supported; throughput is one byte per cycle.
- `drop_cnt` updates at the edge that detects the drop.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined: behaviour as above, and the FSM returns to WAIT_D1 after an emit.
- Undefined: after an emit the FSM returns to IDLE, so every message needs its own status byte. A data byte arriving there is discarded and counted.

## Test plan
- 0x90,0x3C,0x64 → one message: type 1, ch 0, d1 0x3C, d2 0x64; `note_on` = 1; `msg_valid` rises the cycle after the third strobe.
- 0x91,0x40,0x00 → `note_off` = 1, `note_on` = 0. With `MIDI_RUNNING_STATUS_EN`, a following 0x41,0x50 gives a second message: ch 1, d1 0x41, d2 0x50. Without the macro, the same stream leaves no second message and `drop_cnt` = 2.
- 0xC2,0x05,0x07 (running status) → two messages: type 4, d1 0x05 then 0x07, d2 0.
- 0x90,0x3C,0xF8,0x64 → a single note-on; the realtime byte is ignored. 0x90,0x3C,0x80,0x3C,0x00 → `drop_cnt` +1, then one note-off.
- `msg_ready` held 0 and 6 note-ons sent with FIFO_DEPTH = 4 → 4 messages queued in order; `drop_cnt` = 2. 300 stray data bytes in IDLE → `drop_cnt` = 0xFF.
- `CH_MASK` = 16'h0001: 0x93,0x3C,0x64 → no message and `drop_cnt` unchanged. Assert `rst_n` low mid-message with 2 messages queued → `msg_valid` = 0 immediately and `drop_cnt` = 0.
